// File: rtl/projectile_grid_if.sv
// projectile_grid_if: control, fire inputs and field/hit outputs of projectile_grid
interface projectile_grid_if #(
  parameter int COLS  = 160,
  parameter int ROWS  = 120,
  parameter int X_W   = 8,
  parameter int HIT_W = 8
);
  logic                 enable;
  logic                 shoot;
  logic [X_W-1:0]       user_x;
  logic                 enemy_shoot;
  logic [X_W-1:0]       enemy_x;
  logic [COLS*ROWS-1:0] grid;
  logic                 enemy_hit;
  logic                 player_hit;
  logic [HIT_W-1:0]     enemy_hits;
  logic [HIT_W-1:0]     player_hits;
  modport master (
    output enable, shoot, user_x, enemy_shoot, enemy_x,
    input  grid, enemy_hit, player_hit, enemy_hits, player_hits
  );
  modport slave (
    input  enable, shoot, user_x, enemy_shoot, enemy_x,
    output grid, enemy_hit, player_hit, enemy_hits, player_hits
  );
endinterface

// File: rtl/projectile_grid.sv
// projectile_grid: two-plane shot field with collisions and hit counters; PROJECTILE_GRID_COOLDOWN_EN adds fire lockout
module projectile_grid #(
  parameter int COLS         = 160,
  parameter int ROWS         = 120,
  parameter int X_W          = 8,
  parameter int SHIFT_PERIOD = 3125000,
  parameter int HIT_W        = 8,
  parameter int COOLDOWN     = 4
) (
  input logic clock,
  input logic reset,
  projectile_grid_if.slave bus
);
  localparam int N  = COLS*ROWS;
  localparam int CW = $clog2(SHIFT_PERIOD);
  if (SHIFT_PERIOD < 2 || COOLDOWN < 0) begin : g_bad_cfg
    $error("projectile_grid: invalid SHIFT_PERIOD or COOLDOWN");
  end
  logic [CW-1:0]    cnt;
  logic [N-1:0]     p, e, ps, es, p_n, e_n;
  logic             shoot_q, eshoot_q, fire, efire, tick, ehit_n, phit_n, ehit, phit;
  logic [HIT_W-1:0] ehits, phits;
  assign tick = bus.enable && cnt == '0;
`ifdef PROJECTILE_GRID_COOLDOWN_EN
  localparam int LW = COOLDOWN > 0 ? $clog2(COOLDOWN+1) : 1;
  logic [LW-1:0] lock, elock;
  assign fire  = bus.shoot & ~shoot_q & bus.enable & (lock == '0);
  assign efire = bus.enemy_shoot & ~eshoot_q & bus.enable & (elock == '0);
  always_ff @(posedge clock)
    if (reset) begin
      lock  <= '0;
      elock <= '0;
    end else begin
      lock  <= fire ? LW'(COOLDOWN) : (tick && lock != '0) ? lock - 1'b1 : lock;
      elock <= efire ? LW'(COOLDOWN) : (tick && elock != '0) ? elock - 1'b1 : elock;
    end
`else
  assign fire  = bus.shoot & ~shoot_q & bus.enable;
  assign efire = bus.enemy_shoot & ~eshoot_q & bus.enable;
`endif
  // Survivors of same-cell and crossing collisions, taken from the pre-shift planes
  always_comb begin
    ps = p & ~e;
    es = e & ~p;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS-1; r++)
        if (p[ROWS*c+r] & e[ROWS*c+r+1]) begin
          ps[ROWS*c+r]   = 1'b0;
          es[ROWS*c+r+1] = 1'b0;
        end
  end
  always_comb begin
    p_n    = tick ? ps << 1 : p;
    e_n    = tick ? es >> 1 : e;
    ehit_n = 1'b0;
    phit_n = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (tick) begin
        p_n[ROWS*c]        = 1'b0;
        e_n[ROWS*c+ROWS-1] = 1'b0;
        if (ps[ROWS*c+ROWS-1] && int'(bus.enemy_x) == c) ehit_n = 1'b1;
        if (es[ROWS*c] && int'(bus.user_x) == c) phit_n = 1'b1;
      end
      if (fire && int'(bus.user_x) == c) p_n[ROWS*c] = 1'b1;
      if (efire && int'(bus.enemy_x) == c) e_n[ROWS*c+ROWS-1] = 1'b1;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      cnt      <= CW'(SHIFT_PERIOD-1);
      p        <= '0;
      e        <= '0;
      shoot_q  <= 1'b0;
      eshoot_q <= 1'b0;
      ehit     <= 1'b0;
      phit     <= 1'b0;
      ehits    <= '0;
      phits    <= '0;
    end else begin
      if (bus.enable) begin
        cnt      <= tick ? CW'(SHIFT_PERIOD-1) : cnt - 1'b1;
        shoot_q  <= bus.shoot;
        eshoot_q <= bus.enemy_shoot;
      end
      p    <= p_n;
      e    <= e_n;
      ehit <= ehit_n;
      phit <= phit_n;
      if (ehit_n && ~&ehits) ehits <= ehits + 1'b1;
      if (phit_n && ~&phits) phits <= phits + 1'b1;
    end
  assign bus.grid        = p | e;
  assign bus.enemy_hit   = ehit;
  assign bus.player_hit  = phit;
  assign bus.enemy_hits  = ehits;
  assign bus.player_hits = phits;
endmodule

// File: doc/projectile_grid.md
# projectile_grid

Parametrised projectile field that tracks player shots travelling up and enemy shots travelling down across a COLS×ROWS cell grid. Steps both planes on a programmable tick and annihilates opposing shots that meet. Reports hits on the enemy and the player, and exposes the combined occupancy bitmap to the VGA renderer. Generalises the single-direction per-column shot shifter into a two-plane field with edge-detected firing, collision handling and hit reporting.

## Interface
- COLS, 160, number of columns (x positions)
- ROWS, 120, cells per column; row 0 at player, row ROWS-1 at enemy
- X_W, 8, width of x position inputs
- SHIFT_PERIOD, 3125000, clock cycles per shift tick (≥2)
- HIT_W, 8, width of hit counters
- COOLDOWN, 4, shift ticks of fire lockout (used only with macro)

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- enable  in  1  gridUpdateEn; low freezes counter, planes, shot acceptance
- shoot  in  1  player fire level; rising edge fires
- user_x  in  X_W  player column
- enemy_shoot  in  1  enemy fire level; rising edge fires
- enemy_x  in  X_W  enemy column
- grid  out  COLS*ROWS  occupancy; bit ROWS*c+r = cell (c,r) = player_plane | enemy_plane
- enemy_hit  out  1  one-cycle pulse, player shot exited at enemy_x
- player_hit  out  1  one-cycle pulse, enemy shot exited at user_x
- enemy_hits  out  HIT_W  saturating count of enemy_hit pulses
- player_hits  out  HIT_W  saturating count of player_hit pulses

## Operation
- Two planes of COLS×ROWS flops: P (moves to higher row), E (moves to lower row).
- Tick counter: loads SHIFT_PERIOD-1; decrements while enable; at 0 asserts tick for that cycle and reloads.
- Fire detect: shoot_q, eshoot_q register previous levels (update only while enable). Fire = level & ~prev & enable.
- On tick, per column c:
  - P[c][r] ← P[c][r-1]; P[c][0] ← 0.
  - E[c][r] ← E[c][r+1]; E[c][ROWS-1] ← 0.
- Exit at tick:
  - P[c][ROWS-1] set with c==enemy_x → enemy_hit.
  - E[c][0] set with c==user_x → player_hit.
  - Other exits are silently dropped.
- Collision, evaluated on pre-shift state at tick; both shots removed:
  - Same cell: P[c][r]&E[c][r].
  - Crossing: P[c][r]&E[c][r+1], the pair that would swap.
  - A removed shot neither shifts nor can exit/hit.
- Fire injection after shift in the same cycle:
  - P[user_x][0] ← 1.
  - E[enemy_x][ROWS-1] ← 1.
  - x ≥ COLS: shot discarded, no other effect.
- Injected cells are not collision-checked until the next tick.
- Counters increment on their pulse and saturate at all-ones.
- reset clears P, E, shoot_q, eshoot_q, pulses and counters, and loads the tick counter. It overrides every same-cycle event, including a mid-shift tick.

## Timing
- Reset values: grid=0, enemy_hit=0, player_hit=0, enemy_hits=0, player_hits=0.
- grid is driven directly from flops; no combinational path from inputs.
- Fire edge in cycle N: cell visible on grid in cycle N+1.
- First tick occurs SHIFT_PERIOD cycles after reset deasserts. Ticks are then every SHIFT_PERIOD enabled cycles.
- A shot fired at row 0 reaches row ROWS-1 after ROWS-1 ticks and exits on tick ROWS.
- enemy_hit/player_hit assert in the cycle after the exiting tick, for exactly one cycle. Counters update in that same cycle.
- enable low: all state holds, including prev-level registers. An edge occurring while disabled fires on the first enabled cycle only if the level is still high and prev is low.
- Simultaneous enemy_hit and player_hit: both pulse, both counters increment.

## Configuration
- PROJECTILE_GRID_COOLDOWN_EN defined:
  - Each side has a lockout counter loaded with COOLDOWN on an accepted fire, decremented on each tick.
  - Fire edges are ignored while the lockout is nonzero.
  - reset clears the lockouts.
- PROJECTILE_GRID_COOLDOWN_EN undefined: every qualified rising edge fires; no lockout logic is present.

## Test plan
Bench params: COLS=8, ROWS=6, SHIFT_PERIOD=4.
- Reset then idle 40 cycles → grid=0, no pulses, counters 0.
- user_x=3, shoot 0→1 → grid bit 18 set next cycle; after 6 ticks enemy_x=3 sees enemy_hit one cycle and enemy_hits=1. Repeat with enemy_x=5 → no pulse.
- Same-column duel: P fired col 2 at row 0, E fired col 2 at row 5 in the same cycle → both vanish by tick 3 via crossing rule, no hits, grid=0.
- enable=0 for 20 cycles mid-flight → grid unchanged and no ticks; resume → motion continues with the tick phase preserved.
- user_x=9 fire → no grid change. Assert reset on a tick cycle with shots in flight → all outputs 0 next cycle.
- With PROJECTILE_GRID_COOLDOWN_EN, COOLDOWN=2: fire, re-fire within 2 ticks → second ignored; fire after 2 ticks → accepted. Without the macro, both fires accepted.
